// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types for the RV32I multi-cycle control sequencer.
//   state_t      : sequencer state encoding (6 unused, recovers to IDLE)
//   PCSEL_*      : next-PC select codes driven on pc_sel
//   ctrl_word_t  : decoder bits captured once per instruction in DECODE
//   pcSelect()   : next-PC select for the current control word
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;  // PC + 4
  localparam logic [1:0] PCSEL_BR   = 2'b01;  // branch / JAL target
  localparam logic [1:0] PCSEL_JALR = 2'b10;  // JALR target

  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic branchSig;
    logic conJalr;
  } ctrl_word_t;

  // JALR outranks a branch; a branch only redirects when the comparator agrees.
  function automatic logic [1:0] pcSelect(input ctrl_word_t cw, input logic taken);
    if (cw.conJalr)              return PCSEL_JALR;
    else if (cw.branchSig && taken) return PCSEL_BR;
    else                         return PCSEL_SEQ;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
// Instruction/data memory handshake between the sequencer and the memories.
//   imem_req   : instruction fetch request          (sequencer -> memory)
//   imem_ready : instruction word valid this cycle  (memory -> sequencer)
//   dmem_rd    : data read request                  (sequencer -> memory)
//   dmem_wr    : data write request                 (sequencer -> memory)
//   dmem_ready : data access complete this cycle    (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_rd;
  logic dmem_wr;
  logic dmem_ready;

  modport master (output imem_req, dmem_rd, dmem_wr, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_rd, dmem_wr, output imem_ready, dmem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive wait cycles on a memory handshake.
//   clk, rst : clock, synchronous active-high reset
//   clear    : return the count to zero (priority over enable)
//   enable   : a wait cycle is happening now; count it
//   expired  : this wait cycle is the TIMEOUT-th in a row
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int WIDTH   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + WIDTH'(1);
  end

  // Combinational so the caller can trap on the same cycle the limit is hit.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multi-cycle sequencer for the RV32I core: FETCH -> DECODE -> EXEC ->
// [MEM] -> [WB], with ready handshakes and a wait timeout that traps the core.
// Optional build macro: PERF_CNT_EN (adds perf_retired / perf_stall).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   run                level enable, sampled only at instruction boundaries
//   memBus             memory handshake (multicycle_ctrl_fsm_if.master)
//   dec_*              microprogram decoder outputs, sampled in DECODE
//   branch_taken       branch comparator, valid in EXEC
//   ir_load, pc_load   IR / PC load strobes
//   pc_sel             00 PC+4, 01 branch/JAL, 10 JALR
//   rf_we              register-file write strobe
//   busy, trap         instruction in flight / sticky fault
//   state_o            current state encoding
//   perf_retired/stall (PERF_CNT_EN) retired instructions / wait cycles
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_WIDTH    = 8
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_WIDTH   = 32
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  multicycle_ctrl_fsm_if.master         memBus,
  input  logic                          dec_regWrite,
  input  logic                          dec_MemRead,
  input  logic                          dec_MemWrite,
  input  logic                          dec_BranchSig,
  input  logic                          dec_Con_Jalr,
  input  logic                          branch_taken,
  output logic                          ir_load,
  output logic                          pc_load,
  output logic [1:0]                    pc_sel,
  output logic                          rf_we,
  output logic                          busy,
  output logic                          trap,
  output logic [2:0]                    state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]          perf_retired,
  output logic [CNT_WIDTH-1:0]          perf_stall
`endif
);

  state_t     state, nextState, exitState;
  ctrl_word_t ctrlWord;
  logic [1:0] pcSelReg, execPcSel;
  logic       memWait, timedOut;

  // A stalled handshake cycle; anything else restarts the wait count.
  assign memWait   = (state == FETCH && !memBus.imem_ready) ||
                     (state == MEM   && !memBus.dmem_ready);
  assign execPcSel = pcSelect(ctrlWord, branch_taken);
  assign exitState = run ? FETCH : IDLE;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT), .WIDTH(TO_WIDTH)) waitTimer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!memWait),
    .enable  (memWait),
    .expired (timedOut)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Per-instruction registers: decoder bits in DECODE, redirect select in EXEC
  // so a JAL/JALR link write in WB and its PC update land together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlWord <= '0;
      pcSelReg <= PCSEL_SEQ;
    end else begin
      if (state == DECODE)
        ctrlWord <= '{regWrite:  dec_regWrite,  memRead: dec_MemRead,
                      memWrite:  dec_MemWrite,  branchSig: dec_BranchSig,
                      conJalr:   dec_Con_Jalr};
      if (state == EXEC) pcSelReg <= execPcSel;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no
    // latch is inferred for nextState.
    nextState = state;
    case (state)
      IDLE:   nextState = run ? FETCH : IDLE;
      FETCH:  if (memBus.imem_ready) nextState = DECODE;
              else if (timedOut)     nextState = TRAP;
      DECODE: nextState = (dec_MemRead && dec_MemWrite) ? TRAP : EXEC;
      EXEC:   if (ctrlWord.memRead || ctrlWord.memWrite) nextState = MEM;
              else if (ctrlWord.regWrite)                nextState = WB;
              else                                       nextState = exitState;
      MEM:    if (memBus.dmem_ready) nextState = ctrlWord.memRead ? WB : exitState;
              else if (timedOut)     nextState = TRAP;
      WB:     nextState = exitState;
      TRAP:   nextState = TRAP;
      default: nextState = IDLE;  // unused encoding 6
    endcase
  end

  // Output decode: state + registered control word; only ready/branch_taken
  // handshakes reach outputs combinationally.
  always_comb begin
    memBus.imem_req = 1'b0;
    memBus.dmem_rd  = 1'b0;
    memBus.dmem_wr  = 1'b0;
    ir_load         = 1'b0;
    pc_load         = 1'b0;
    pc_sel          = PCSEL_SEQ;
    rf_we           = 1'b0;
    busy            = 1'b0;
    trap            = 1'b0;
    case (state)
      FETCH: begin
        busy            = 1'b1;
        memBus.imem_req = 1'b1;
        ir_load         = memBus.imem_ready;
      end
      DECODE: busy = 1'b1;
      EXEC: begin
        busy    = 1'b1;
        pc_sel  = execPcSel;
        pc_load = !(ctrlWord.memRead || ctrlWord.memWrite || ctrlWord.regWrite);
      end
      MEM: begin
        busy           = 1'b1;
        pc_sel         = pcSelReg;
        memBus.dmem_rd = ctrlWord.memRead;
        memBus.dmem_wr = ctrlWord.memWrite;
        pc_load        = memBus.dmem_ready && ctrlWord.memWrite;
      end
      WB: begin
        busy    = 1'b1;
        pc_sel  = pcSelReg;
        rf_we   = 1'b1;
        pc_load = 1'b1;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef PERF_CNT_EN
  // Neither event can occur in TRAP, so both counters freeze there.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (pc_load) perf_retired <= perf_retired + CNT_WIDTH'(1);
      if (memWait) perf_stall   <= perf_stall + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Directed-vector bench for multicycle_ctrl_fsm, built with MEM_TIMEOUT=4.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run;
  logic dec_regWrite, dec_MemRead, dec_MemWrite, dec_BranchSig, dec_Con_Jalr;
  logic branch_taken;
  logic ir_load, pc_load, rf_we, busy, trap;
  logic [1:0] pc_sel;
  logic [2:0] state_o;
`ifdef PERF_CNT_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  multicycle_ctrl_fsm_if memBus ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .memBus        (memBus.master),
    .dec_regWrite  (dec_regWrite),
    .dec_MemRead   (dec_MemRead),
    .dec_MemWrite  (dec_MemWrite),
    .dec_BranchSig (dec_BranchSig),
    .dec_Con_Jalr  (dec_Con_Jalr),
    .branch_taken  (branch_taken),
    .ir_load       (ir_load),
    .pc_load       (pc_load),
    .pc_sel        (pc_sel),
    .rf_we         (rf_we),
    .busy          (busy),
    .trap          (trap),
    .state_o       (state_o)
`ifdef PERF_CNT_EN
    ,
    .perf_retired  (perf_retired),
    .perf_stall    (perf_stall)
`endif
  );

  int passCnt  = 0;
  int totalCnt = 0;

  // Observed output word: {state_o, imem_req, ir_load, pc_load, pc_sel,
  //                        dmem_rd, dmem_wr, rf_we, busy, trap}
  wire [12:0] obs = {state_o, memBus.imem_req, ir_load, pc_load, pc_sel,
                     memBus.dmem_rd, memBus.dmem_wr, rf_we, busy, trap};

  function automatic logic [12:0] ev(input int st, input bit req, input bit irl,
                                     input bit pcl, input logic [1:0] sel,
                                     input bit rd, input bit wr, input bit we,
                                     input bit bsy, input bit trp);
    return {3'(st), req, irl, pcl, sel, rd, wr, we, bsy, trp};
  endfunction

  // Stimulus word: {run, imem_ready, dmem_ready, regWrite, MemRead, MemWrite,
  //                 BranchSig, Con_Jalr, branch_taken}
  function automatic logic [8:0] sv(input bit rn, input bit ir, input bit dr,
                                    input bit rw, input bit mr, input bit mw,
                                    input bit bs, input bit cj, input bit bt);
    return {rn, ir, dr, rw, mr, mw, bs, cj, bt};
  endfunction

  task automatic apply(input logic [8:0] s);
    run               = s[8];
    memBus.imem_ready = s[7];
    memBus.dmem_ready = s[6];
    dec_regWrite      = s[5];
    dec_MemRead       = s[4];
    dec_MemWrite      = s[3];
    dec_BranchSig     = s[2];
    dec_Con_Jalr      = s[1];
    branch_taken      = s[0];
  endtask

  // Expected output words by state/situation
  logic [12:0] eIdle, eFetchRdy, eFetchWait, eDecode, eExecPlain, eWbAlu;
  logic [12:0] eMemLoad, eMemStoreDone, eExecBrTaken, eExecJalr, eWbJalr, eTrap;

  initial begin
    eIdle         = ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    eFetchRdy     = ev(1, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0);
    eFetchWait    = ev(1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    eDecode       = ev(2, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    eExecPlain    = ev(3, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    eWbAlu        = ev(5, 0, 0, 1, 2'b00, 0, 0, 1, 1, 0);
    eMemLoad      = ev(4, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0);
    eMemStoreDone = ev(4, 0, 0, 1, 2'b00, 0, 1, 0, 1, 0);
    eExecBrTaken  = ev(3, 0, 0, 1, 2'b01, 0, 0, 0, 1, 0);
    eExecJalr     = ev(3, 0, 0, 0, 2'b10, 0, 0, 0, 1, 0);
    eWbJalr       = ev(5, 0, 0, 1, 2'b10, 0, 0, 1, 1, 0);
    eTrap         = ev(7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
  end

  task automatic test_reset();
    rst = 1'b1;
    apply('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    totalCnt++;
    if (obs !== eIdle) $display("FAIL reset: obs=%h exp=%h", obs, eIdle);
    else passCnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One rst pulse from any state; the sequencer must come back in IDLE.
  task automatic test_trap_release(input string name);
    apply('0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (obs !== eIdle) $display("FAIL %s release: obs=%h exp=%h", name, obs, eIdle);
    else passCnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [8:0]  s [10];
    logic [12:0] e [10];
    for (int i = 0; i < 10; i++) s[i] = sv(i < 5, 1, 1, 1, 0, 0, 0, 0, 0);
    e = '{eIdle, eFetchRdy, eDecode, eExecPlain, eWbAlu,
          eFetchRdy, eDecode, eExecPlain, eWbAlu, eIdle};
    for (int i = 0; i < 10; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL alu cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
  endtask

  // Three dmem stalls, ready on the fourth MEM cycle: the cycle the timeout
  // would otherwise fire, so this also covers ready-beats-timeout.
  task automatic test_load_stall();
    logic [8:0]  s [10];
    logic [12:0] e [10];
    for (int i = 0; i < 10; i++) s[i] = sv(i < 4, 1, i >= 7, 1, 1, 0, 0, 0, 0);
    e = '{eIdle, eFetchRdy, eDecode, eExecPlain, eMemLoad,
          eMemLoad, eMemLoad, eMemLoad, eWbAlu, eIdle};
    for (int i = 0; i < 10; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL load cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
`ifdef PERF_CNT_EN
    totalCnt++;
    if (perf_stall !== 32'd3) $display("FAIL perf_stall: obs=%0d exp=3", perf_stall);
    else passCnt++;
    totalCnt++;
    if (perf_retired !== 32'd3) $display("FAIL perf_retired: obs=%0d exp=3", perf_retired);
    else passCnt++;
`endif
  endtask

  task automatic test_store_branch();
    logic [8:0]  s [9];
    logic [12:0] e [9];
    for (int i = 0; i < 5; i++) s[i] = sv(1, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 5; i < 9; i++) s[i] = sv(i < 7, 1, 1, 0, 0, 0, 1, 0, 1);
    e = '{eIdle, eFetchRdy, eDecode, eExecPlain, eMemStoreDone,
          eFetchRdy, eDecode, eExecBrTaken, eIdle};
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL store_branch cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
  endtask

  // JALR with link write: the 10 select must still be on pc_sel in WB.
  task automatic test_jalr();
    logic [8:0]  s [6];
    logic [12:0] e [6];
    for (int i = 0; i < 6; i++) s[i] = sv(i < 4, 1, 1, 1, 0, 0, 0, 1, 0);
    e = '{eIdle, eFetchRdy, eDecode, eExecJalr, eWbJalr, eIdle};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL jalr cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_run_drop();
    logic [8:0]  s [6];
    logic [12:0] e [6];
    for (int i = 0; i < 6; i++) s[i] = sv(i < 3, 1, 1, 1, 0, 0, 0, 0, 0);
    e = '{eIdle, eFetchRdy, eDecode, eExecPlain, eWbAlu, eIdle};
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL run_drop cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
  endtask

  // Four fetch waits trap; ready/run afterwards must not leave TRAP.
  task automatic test_fetch_timeout();
    logic [8:0]  s [7];
    logic [12:0] e [7];
    for (int i = 0; i < 7; i++) s[i] = sv(1, i >= 5, i >= 5, 1, 0, 0, 0, 0, 0);
    e = '{eIdle, eFetchWait, eFetchWait, eFetchWait, eFetchWait, eTrap, eTrap};
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL fetch_timeout cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
    test_trap_release("fetch_timeout");
  endtask

  task automatic test_decode_trap();
    logic [8:0]  s [5];
    logic [12:0] e [5];
    for (int i = 0; i < 5; i++) s[i] = sv(1, 1, 1, 0, 1, 1, 0, 0, 0);
    e = '{eIdle, eFetchRdy, eDecode, eTrap, eTrap};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL decode_trap cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
    test_trap_release("decode_trap");
  endtask

  // rst raised while a load waits in MEM: request visible until the edge,
  // gone (and state 0) on the following cycle.
  task automatic test_mem_reset();
    logic [8:0]  s [5];
    logic [12:0] e [5];
    for (int i = 0; i < 5; i++) s[i] = sv(1, 1, 0, 1, 1, 0, 0, 0, 0);
    e = '{eIdle, eFetchRdy, eDecode, eExecPlain, eMemLoad};
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      @(negedge clk);
      totalCnt++;
      if (obs !== e[i]) $display("FAIL mem_reset cycle %0d: obs=%h exp=%h", i, obs, e[i]);
      else passCnt++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    totalCnt++;
    if (obs !== eMemLoad) $display("FAIL mem_reset rst-high: obs=%h exp=%h", obs, eMemLoad);
    else passCnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (obs !== eIdle) $display("FAIL mem_reset after: obs=%h exp=%h", obs, eIdle);
    else passCnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_stall();
    test_store_branch();
    test_jalr();
    test_run_drop();
    test_fetch_timeout();
    test_decode_trap();
    test_mem_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
